// File: rtl/motor_pwm_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | motor_pwm_ctrl: N-channel H-bridge PWM controller with slew-limited duty, |
// | reversal dead-time and latched overcurrent shutdown.   Rev 1.0            |
// +----------------------------------------------------------------------------+
module motor_pwm_ctrl #(
  parameter int NUM_CH       = 2,
  parameter int CNT_W        = 12,
  parameter int PERIOD       = 2500,
  parameter int RAMP_STEP    = 125,
  parameter int DEAD_PERIODS = 2,
  parameter int OC_W         = 21,
  parameter int OC_LIMIT     = 2499
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*CNT_W-1:0] duty_cmd,
  input  logic [NUM_CH-1:0]       dir_cmd,
  input  logic [NUM_CH-1:0]       oc_sense,
  input  logic [NUM_CH-1:0]       fault_clr,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic [NUM_CH-1:0]       in1,
  output logic [NUM_CH-1:0]       in2,
  output logic [NUM_CH-1:0]       fault,
  output logic                    period_tick
);

  localparam int DW = $clog2(DEAD_PERIODS + 2);

  localparam logic [1:0] C_ST_RUN   = 2'd0;
  localparam logic [1:0] C_ST_RDN   = 2'd1;
  localparam logic [1:0] C_ST_DEAD  = 2'd2;
  localparam logic [1:0] C_ST_FAULT = 2'd3;

  localparam logic [CNT_W-1:0] C_PERIOD = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] C_LAST   = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] C_STEP   = CNT_W'(RAMP_STEP);
  localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);
  localparam logic [DW-1:0]    C_DEAD   = DW'(DEAD_PERIODS);
  localparam logic [DW-1:0]    C_D_ONE  = DW'(1);
  localparam logic [OC_W-1:0]  C_OCLIM  = OC_W'(OC_LIMIT);
  localparam logic [OC_W-1:0]  C_OC_ONE = OC_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q;

  always_comb begin
    cnt_d = (cnt_q == C_LAST) ? '0 : cnt_q + C_ONE;
  end

  // tick is registered from the next count so it coincides with cnt == PERIOD-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == C_LAST);
    end
  end

  assign period_tick = tick_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [CNT_W-1:0] w_cmd, w_clamped, w_tgt, w_ramped;
    logic [CNT_W-1:0] applied_q, applied_d;
    logic [1:0]       state_q, state_d;
    logic             cur_dir_q, cur_dir_d;
    logic [DW-1:0]    dead_q, dead_d;
    logic [OC_W-1:0]  oc_cnt_q, oc_cnt_d;
    logic             sync1_q, sync2_q;
    logic             pwm_q, in1_q, in2_q, fault_q;
    logic             w_drive;

    assign w_cmd     = duty_cmd[k*CNT_W +: CNT_W];
    assign w_clamped = (w_cmd > C_PERIOD) ? C_PERIOD : w_cmd;
    assign w_tgt     = (state_q == C_ST_RUN) ? w_clamped : '0;

    always_comb begin
      if (applied_q < w_tgt)
        w_ramped = ((w_tgt - applied_q) > C_STEP) ? applied_q + C_STEP : w_tgt;
      else
        w_ramped = ((applied_q - w_tgt) > C_STEP) ? applied_q - C_STEP : w_tgt;
    end

    always_comb begin
      if (!sync2_q)
        oc_cnt_d = '0;
      else if (oc_cnt_q == C_OCLIM)
        oc_cnt_d = oc_cnt_q;
      else
        oc_cnt_d = oc_cnt_q + C_OC_ONE;
    end

    always_comb begin
      state_d   = state_q;
      cur_dir_d = cur_dir_q;
      dead_d    = dead_q;
      applied_d = tick_q ? w_ramped : applied_q;
      case (state_q)
        C_ST_RUN: begin
          if (dir_cmd[k] != cur_dir_q) state_d = C_ST_RDN;
        end
        C_ST_RDN: begin
          if (dir_cmd[k] == cur_dir_q) begin
            state_d = C_ST_RUN;
          end else if (tick_q && (applied_q == '0)) begin
            state_d = C_ST_DEAD;
            dead_d  = C_DEAD;
          end
        end
        C_ST_DEAD: begin
          applied_d = '0;
          if (tick_q) begin
            if (dead_q <= C_D_ONE) begin
              state_d   = C_ST_RUN;
              cur_dir_d = dir_cmd[k];
              dead_d    = '0;
            end else begin
              dead_d = dead_q - C_D_ONE;
            end
          end
        end
        C_ST_FAULT: begin
          applied_d = '0;
          if (fault_clr[k] && !sync2_q && (oc_cnt_q == '0)) begin
            state_d = C_ST_DEAD;
            dead_d  = C_DEAD;
          end
        end
        default: state_d = C_ST_DEAD;
      endcase
      if (oc_cnt_q == C_OCLIM) begin
        state_d   = C_ST_FAULT;
        applied_d = '0;
      end
    end

    // The bridge keeps switching while ramping down; only DEAD and FAULT silence it.
    assign w_drive = (state_d == C_ST_RUN) || (state_d == C_ST_RDN);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q   <= 1'b0;
        sync2_q   <= 1'b0;
        oc_cnt_q  <= '0;
        applied_q <= '0;
        state_q   <= C_ST_DEAD;
        cur_dir_q <= 1'b1;
        dead_q    <= C_DEAD;
        pwm_q     <= 1'b0;
        in1_q     <= 1'b0;
        in2_q     <= 1'b0;
        fault_q   <= 1'b0;
      end else begin
        sync1_q   <= oc_sense[k];
        sync2_q   <= sync1_q;
        oc_cnt_q  <= oc_cnt_d;
        applied_q <= applied_d;
        state_q   <= state_d;
        cur_dir_q <= cur_dir_d;
        dead_q    <= dead_d;
        pwm_q     <= w_drive && (cnt_d < applied_d);
        in1_q     <= w_drive && cur_dir_d;
        in2_q     <= w_drive && !cur_dir_d;
        fault_q   <= (state_d == C_ST_FAULT);
      end
    end

    assign pwm_out[k] = pwm_q;
    assign in1[k]     = in1_q;
    assign in2[k]     = in2_q;
    assign fault[k]   = fault_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_motor_pwm_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_motor_pwm_ctrl: directed bench for motor_pwm_ctrl on a scaled carrier. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_motor_pwm_ctrl;
  localparam int NCH  = 2;
  localparam int CW   = 12;
  localparam int P    = 200;
  localparam int STEP = 10;
  localparam int DP   = 2;
  localparam int OCL  = 199;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NCH*CW-1:0]   duty_cmd;
  logic [NCH-1:0]      dir_cmd, oc_sense, fault_clr;
  logic [NCH-1:0]      pwm_out, in1, in2, fault;
  logic                period_tick;
  int                  checks = 0;
  int                  errors = 0;
  int                  n;

  always #5 clk = ~clk;

  motor_pwm_ctrl #(
    .NUM_CH(NCH), .CNT_W(CW), .PERIOD(P), .RAMP_STEP(STEP),
    .DEAD_PERIODS(DP), .OC_W(21), .OC_LIMIT(OCL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .duty_cmd(duty_cmd), .dir_cmd(dir_cmd),
    .oc_sense(oc_sense), .fault_clr(fault_clr), .pwm_out(pwm_out),
    .in1(in1), .in2(in2), .fault(fault), .period_tick(period_tick)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_tick();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (period_tick !== 1'b1 && k < P + 5);
    chk("tick_seen", int'(period_tick), 1);
  endtask

  // Counts one full carrier period; dir code is {in1,in2}: 2=fwd 1=rev 0=off.
  task automatic period_chk(input string tag, input int e_hi0, input int e_dir0,
                            input int e_hi1, input int e_dir1);
    int hi0, hi1, d0, d1;
    hi0 = 0; hi1 = 0; d0 = -1; d1 = -1;
    for (int i = 0; i < P; i++) begin
      @(negedge clk);
      hi0 += int'(pwm_out[0]);
      hi1 += int'(pwm_out[1]);
      if (i == P / 2) begin
        d0 = int'({in1[0], in2[0]});
        d1 = int'({in1[1], in2[1]});
      end
    end
    if (e_hi0 >= 0) chk({tag, "_hi0"}, hi0, e_hi0);
    chk({tag, "_dir0"}, d0, e_dir0);
    if (e_hi1 >= 0) chk({tag, "_hi1"}, hi1, e_hi1);
    chk({tag, "_dir1"}, d1, e_dir1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    duty_cmd  = {12'd50, 12'd100};
    dir_cmd   = 2'b11;
    oc_sense  = 2'b00;
    fault_clr = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_in1", int'(in1), 0);
    chk("rst_in2", int'(in2), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_tick", int'(period_tick), 0);

    // Startup: two dead periods, then forward ramp 10 per period.
    rst_n = 1'b1;
    wait_tick();
    chk("p1_in", int'({in1, in2}), 0);
    period_chk("dead2", 0, 0, 0, 0);
    period_chk("run0", 0, 2, 0, 2);
    for (int i = 1; i <= 11; i++)
      period_chk($sformatf("ramp%0d", i), (10*i > 100) ? 100 : 10*i, 2,
                 (10*i > 50) ? 50 : 10*i, 2);

    // Over-range command clamps at PERIOD: fully on, including the wrap.
    duty_cmd[11:0] = 12'd300;
    for (int i = 1; i <= 11; i++)
      period_chk($sformatf("over%0d", i), (100 + 10*i > 200) ? 200 : 100 + 10*i, 2, 50, 2);

    // Reversal: 21 periods still forward while ramping 200 to 0, 2 dead, then reverse.
    dir_cmd[0] = 1'b0;
    for (int j = 0; j <= 20; j++)
      period_chk($sformatf("rdn%0d", j), -1, 2, 50, 2);
    period_chk("rdead_a", 0, 0, 50, 2);
    period_chk("rdead_b", 0, 0, 50, 2);
    period_chk("rev0", 0, 1, 50, 2);
    period_chk("rev1", 10, 1, 50, 2);
    period_chk("rev2", 20, 1, 50, 2);
    duty_cmd[11:0] = 12'd20;
    period_chk("hold", 20, 1, 50, 2);

    // Overcurrent one cycle short of the limit must not trip.
    oc_sense[1] = 1'b1;
    repeat (OCL - 1) @(negedge clk);
    oc_sense[1] = 1'b0;
    repeat (10) @(negedge clk);
    chk("oc_short_nofault", int'(fault), 0);

    oc_sense[1] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (fault[1] !== 1'b1 && n < OCL + 10);
    chk("oc_trip", int'(fault[1]), 1);
    chk("oc_latency_ok", int'(n >= OCL && n <= OCL + 3), 1);
    chk("oc_pwm1", int'(pwm_out[1]), 0);
    chk("oc_in1", int'(in1[1]), 0);
    chk("oc_in2", int'(in2[1]), 0);
    chk("oc_ch0_fault", int'(fault[0]), 0);
    wait_tick();
    period_chk("ch0_ok", 20, 1, 0, 0);

    // Clear is ignored while overcurrent persists.
    fault_clr[1] = 1'b1;
    repeat (50) @(negedge clk);
    chk("clr_held", int'(fault[1]), 1);
    oc_sense[1] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (fault[1] !== 1'b0 && n < 10);
    chk("clr_done", int'(fault[1]), 0);
    chk("clr_dead_in", int'({in1[1], in2[1]}), 0);
    wait_tick();
    period_chk("fdead", 20, 1, 0, 0);
    period_chk("frun0", 20, 1, 0, 2);
    period_chk("framp", 20, 1, 10, 2);
    fault_clr[1] = 1'b0;

    // Asynchronous reset in the middle of a high pulse.
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pwm_out[0] !== 1'b1 && n < P);
    chk("pre_rst_pwm", int'(pwm_out[0]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pwm", int'(pwm_out), 0);
    chk("arst_in1", int'(in1), 0);
    chk("arst_in2", int'(in2), 0);
    chk("arst_fault", int'(fault), 0);
    chk("arst_tick", int'(period_tick), 0);
    duty_cmd = {12'd50, 12'd100};
    dir_cmd  = 2'b11;
    @(negedge clk);
    rst_n = 1'b1;
    wait_tick();
    chk("r_p1_in", int'({in1, in2}), 0);
    period_chk("r_dead2", 0, 0, 0, 0);
    period_chk("r_run0", 0, 2, 0, 2);
    period_chk("r_ramp1", 10, 2, 10, 2);
    period_chk("r_ramp2", 20, 2, 20, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
